// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, FSM state types and parity helpers for uart_xcvr.
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   localparam int         OVERSAMPLE = 16;
   localparam logic [3:0] MID_SAMPLE = 4'd7;
   localparam logic [3:0] LAST_PHASE = 4'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_e;

   // Parity bit that makes data+parity even (odd=0) or odd (odd=1); data zero-extended to 9 bits.
   function automatic logic par_calc(input logic [8:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

   // True when the mode carries a parity bit; the reserved code behaves as none.
   function automatic logic par_used(input logic [1:0] m);
      case (m)
         PAR_EVEN, PAR_ODD: return 1'b1;
         PAR_NONE:          return 1'b0;
         default:           return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator; counts 0..div and pulses tick at wrap.
// clr restarts the count so a frame's bit windows align with its start.
module uart_baud_tick #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             wrap_s;

   // Next count: restart on clr or wrap, otherwise increment.
   always_comb begin
      wrap_s = (cnt_q == div);
      if (clr) begin
         cnt_d = '0;
      end else if (wrap_s) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + DIV_W'(1);
      end
   end

   assign tick = wrap_s & ~clr;

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_xcvr.sv
// uart_xcvr: full-duplex UART with runtime divisor, 16x oversampled receive,
// optional parity, 1 or 2 stop bits and valid/ready handshakes.
// Optional feature macro: UART_LOOPBACK_EN adds a 'loopback' input that routes
// the internal tx into the receiver and holds the tx pin high.
module uart_xcvr
   import uart_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int STOP_BITS = 1,
   parameter int DIV_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DIV_W-1:0]  baud_div,
   input  logic [1:0]        parity_mode,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx,
   input  logic              rx,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              rx_parity_err,
   output logic              rx_frame_err,
   output logic              rx_overrun
`ifdef UART_LOOPBACK_EN
   ,
   input  logic              loopback
`endif
);

   localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

   // ---------------- transmit ----------------
   tx_state_e         tx_st_q, tx_st_d;
   logic [DATA_W-1:0] tx_shr_q, tx_shr_d;
   logic [DIV_W-1:0]  tx_div_q, tx_div_d;
   logic [1:0]        tx_mode_q, tx_mode_d;
   logic [3:0]        tx_ph_q, tx_ph_d;
   logic [3:0]        tx_idx_q, tx_idx_d;
   logic              tx_stop_q, tx_stop_d;
   logic              tx_par_q, tx_par_d;
   logic              tx_q, tx_d;
   logic              tx_rdy_q, tx_rdy_d;
   logic              tx_tick_s, tx_clr_s, tx_bit_end_s;

   uart_baud_tick #(.DIV_W(DIV_W)) u_tx_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (tx_clr_s),
      .div  (tx_div_q),
      .tick (tx_tick_s)
   );

   // TX next state: each bit lasts 16 ticks; data is shifted out LSB first.
   always_comb begin
      tx_st_d      = tx_st_q;
      tx_shr_d     = tx_shr_q;
      tx_div_d     = tx_div_q;
      tx_mode_d    = tx_mode_q;
      tx_idx_d     = tx_idx_q;
      tx_stop_d    = tx_stop_q;
      tx_par_d     = tx_par_q;
      tx_d         = tx_q;
      tx_rdy_d     = tx_rdy_q;
      tx_clr_s     = 1'b0;
      tx_bit_end_s = tx_tick_s && (tx_ph_q == LAST_PHASE);
      tx_ph_d      = tx_tick_s ? (tx_ph_q + 4'd1) : tx_ph_q;
      case (tx_st_q)
         TX_IDLE: begin
            tx_d     = 1'b1;
            tx_rdy_d = 1'b1;
            if (tx_valid && tx_rdy_q) begin
               tx_st_d   = TX_START;
               tx_rdy_d  = 1'b0;
               tx_d      = 1'b0;
               tx_shr_d  = tx_data;
               tx_div_d  = baud_div;
               tx_mode_d = parity_mode;
               tx_par_d  = par_calc(9'(tx_data), parity_mode == PAR_ODD);
               tx_clr_s  = 1'b1;
               tx_ph_d   = 4'd0;
            end else begin
               tx_st_d = TX_IDLE;
            end
         end
         TX_START: begin
            if (tx_bit_end_s) begin
               tx_st_d  = TX_DATA;
               tx_d     = tx_shr_q[0];
               tx_shr_d = tx_shr_q >> 1;
               tx_idx_d = 4'd0;
            end else begin
               tx_st_d = TX_START;
            end
         end
         TX_DATA: begin
            if (tx_bit_end_s && (tx_idx_q == LAST_DATA)) begin
               tx_stop_d = 1'b0;
               if (par_used(tx_mode_q)) begin
                  tx_st_d = TX_PARITY;
                  tx_d    = tx_par_q;
               end else begin
                  tx_st_d = TX_STOP;
                  tx_d    = 1'b1;
               end
            end else if (tx_bit_end_s) begin
               tx_idx_d = tx_idx_q + 4'd1;
               tx_d     = tx_shr_q[0];
               tx_shr_d = tx_shr_q >> 1;
            end else begin
               tx_st_d = TX_DATA;
            end
         end
         TX_PARITY: begin
            if (tx_bit_end_s) begin
               tx_st_d   = TX_STOP;
               tx_d      = 1'b1;
               tx_stop_d = 1'b0;
            end else begin
               tx_st_d = TX_PARITY;
            end
         end
         TX_STOP: begin
            tx_d = 1'b1;
            if (tx_bit_end_s && (tx_stop_q == LAST_STOP)) begin
               tx_st_d  = TX_IDLE;
               tx_rdy_d = 1'b1;
            end else if (tx_bit_end_s) begin
               tx_stop_d = tx_stop_q + 1'b1;
            end else begin
               tx_st_d = TX_STOP;
            end
         end
         default: begin
            tx_st_d  = TX_IDLE;
            tx_d     = 1'b1;
            tx_rdy_d = 1'b1;
         end
      endcase
   end

   // TX state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_st_q   <= TX_IDLE;
         tx_shr_q  <= '0;
         tx_div_q  <= '0;
         tx_mode_q <= PAR_NONE;
         tx_ph_q   <= 4'd0;
         tx_idx_q  <= 4'd0;
         tx_stop_q <= 1'b0;
         tx_par_q  <= 1'b0;
         tx_q      <= 1'b1;
         tx_rdy_q  <= 1'b1;
      end else begin
         tx_st_q   <= tx_st_d;
         tx_shr_q  <= tx_shr_d;
         tx_div_q  <= tx_div_d;
         tx_mode_q <= tx_mode_d;
         tx_ph_q   <= tx_ph_d;
         tx_idx_q  <= tx_idx_d;
         tx_stop_q <= tx_stop_d;
         tx_par_q  <= tx_par_d;
         tx_q      <= tx_d;
         tx_rdy_q  <= tx_rdy_d;
      end
   end

   // ---------------- receive ----------------
   logic              rx_in_s, rx_s;
   logic [1:0]        sync_q, sync_d;
   logic              rx_prev_q;
   rx_state_e         rx_st_q, rx_st_d;
   logic [DATA_W-1:0] rx_shr_q, rx_shr_d;
   logic [DIV_W-1:0]  rx_div_q, rx_div_d;
   logic [1:0]        rx_mode_q, rx_mode_d;
   logic [3:0]        rx_ph_q, rx_ph_d;
   logic [3:0]        rx_idx_q, rx_idx_d;
   logic              rx_perr_q, rx_perr_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              rx_pe_q, rx_pe_d;
   logic              rx_fe_q, rx_fe_d;
   logic              rx_ovr_q, rx_ovr_d;
   logic              rx_tick_s, rx_clr_s, rx_sample_s, rx_done_s;

`ifdef UART_LOOPBACK_EN
   assign rx_in_s = loopback ? tx_q : rx;
   assign tx      = tx_q | loopback;
`else
   assign rx_in_s = rx;
   assign tx      = tx_q;
`endif

   assign rx_s = sync_q[1];

   uart_baud_tick #(.DIV_W(DIV_W)) u_rx_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (rx_clr_s),
      .div  (rx_div_q),
      .tick (rx_tick_s)
   );

   // RX next state: start edge realigns the phase, every bit is sampled at mid-bit.
   always_comb begin
      sync_d      = {sync_q[0], rx_in_s};
      rx_st_d     = rx_st_q;
      rx_shr_d    = rx_shr_q;
      rx_div_d    = rx_div_q;
      rx_mode_d   = rx_mode_q;
      rx_idx_d    = rx_idx_q;
      rx_perr_d   = rx_perr_q;
      rx_clr_s    = 1'b0;
      rx_done_s   = 1'b0;
      rx_sample_s = rx_tick_s && (rx_ph_q == MID_SAMPLE);
      rx_ph_d     = rx_tick_s ? (rx_ph_q + 4'd1) : rx_ph_q;
      case (rx_st_q)
         RX_IDLE: begin
            if (rx_prev_q && !rx_s) begin
               rx_st_d   = RX_START;
               rx_clr_s  = 1'b1;
               rx_ph_d   = 4'd0;
               rx_div_d  = baud_div;
               rx_mode_d = parity_mode;
               rx_perr_d = 1'b0;
            end else begin
               rx_st_d = RX_IDLE;
            end
         end
         RX_START: begin
            if (rx_sample_s) begin
               rx_st_d  = rx_s ? RX_IDLE : RX_DATA;
               rx_idx_d = 4'd0;
            end else begin
               rx_st_d = RX_START;
            end
         end
         RX_DATA: begin
            if (rx_sample_s) begin
               rx_shr_d = {rx_s, rx_shr_q[DATA_W-1:1]};
               rx_idx_d = rx_idx_q + 4'd1;
               if (rx_idx_q == LAST_DATA) begin
                  rx_st_d = par_used(rx_mode_q) ? RX_PARITY : RX_STOP;
               end else begin
                  rx_st_d = RX_DATA;
               end
            end else begin
               rx_st_d = RX_DATA;
            end
         end
         RX_PARITY: begin
            if (rx_sample_s) begin
               rx_perr_d = rx_s ^ par_calc(9'(rx_shr_q), rx_mode_q == PAR_ODD);
               rx_st_d   = RX_STOP;
            end else begin
               rx_st_d = RX_PARITY;
            end
         end
         RX_STOP: begin
            if (rx_sample_s) begin
               rx_done_s = 1'b1;
               rx_st_d   = RX_IDLE;
            end else begin
               rx_st_d = RX_STOP;
            end
         end
         default: begin
            rx_st_d = RX_IDLE;
         end
      endcase
   end

   // RX holding register: a finished frame loads unless unconsumed data is held.
   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      rx_pe_d    = rx_pe_q;
      rx_fe_d    = rx_fe_q;
      rx_ovr_d   = 1'b0;
      if (rx_done_s && (!rx_valid_q || rx_ready)) begin
         rx_data_d  = rx_shr_q;
         rx_valid_d = 1'b1;
         rx_pe_d    = rx_perr_q;
         rx_fe_d    = ~rx_s;
      end else if (rx_done_s) begin
         rx_ovr_d = 1'b1;
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end else begin
         rx_valid_d = rx_valid_q;
      end
   end

   // RX synchronizer, state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q     <= 2'b11;
         rx_prev_q  <= 1'b1;
         rx_st_q    <= RX_IDLE;
         rx_shr_q   <= '0;
         rx_div_q   <= '0;
         rx_mode_q  <= PAR_NONE;
         rx_ph_q    <= 4'd0;
         rx_idx_q   <= 4'd0;
         rx_perr_q  <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_pe_q    <= 1'b0;
         rx_fe_q    <= 1'b0;
         rx_ovr_q   <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         rx_prev_q  <= rx_s;
         rx_st_q    <= rx_st_d;
         rx_shr_q   <= rx_shr_d;
         rx_div_q   <= rx_div_d;
         rx_mode_q  <= rx_mode_d;
         rx_ph_q    <= rx_ph_d;
         rx_idx_q   <= rx_idx_d;
         rx_perr_q  <= rx_perr_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_pe_q    <= rx_pe_d;
         rx_fe_q    <= rx_fe_d;
         rx_ovr_q   <= rx_ovr_d;
      end
   end

   assign tx_ready      = tx_rdy_q;
   assign rx_data       = rx_data_q;
   assign rx_valid      = rx_valid_q;
   assign rx_parity_err = rx_pe_q;
   assign rx_frame_err  = rx_fe_q;
   assign rx_overrun    = rx_ovr_q;

endmodule

// File: tb/tb_uart_xcvr.sv
// tb_uart_xcvr: self-checking bench for uart_xcvr (default build, 8 data bits, 1 stop bit).
module tb_uart_xcvr;

   localparam int DATA_W    = 8;
   localparam int STOP_BITS = 1;
   localparam int DIV_W     = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DIV_W-1:0]  baud_div = '0;
   logic [1:0]        parity_mode = 2'b00;
   logic [DATA_W-1:0] tx_data = '0;
   logic              tx_valid = 1'b0;
   logic              tx_ready;
   logic              tx;
   logic              rx_w;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready = 1'b0;
   logic              rx_parity_err;
   logic              rx_frame_err;
   logic              rx_overrun;

   logic rx_drv  = 1'b1;
   logic lb_wire = 1'b0;
   assign rx_w = lb_wire ? tx : rx_drv;

   int vectors = 0;
   int errors  = 0;
   int ovr_seen;
   bit frame_q[$];

   uart_xcvr #(.DATA_W(DATA_W), .STOP_BITS(STOP_BITS), .DIV_W(DIV_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .baud_div      (baud_div),
      .parity_mode   (parity_mode),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .tx            (tx),
      .rx            (rx_w),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .rx_parity_err (rx_parity_err),
      .rx_frame_err  (rx_frame_err),
      .rx_overrun    (rx_overrun)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference frame: start, data LSB first, parity from the ones count, stop bits.
   task automatic build_frame(input logic [7:0] data, input logic [1:0] pm,
                              input bit stop_val, input bit flip_par);
      bit p;
      frame_q.delete();
      frame_q.push_back(1'b0);
      for (int i = 0; i < DATA_W; i++) frame_q.push_back(data[i]);
      if (pm == 2'b01 || pm == 2'b10) begin
         p = (($countones(data) % 2) == 1);
         if (pm == 2'b10) p = !p;
         if (flip_par) p = !p;
         frame_q.push_back(p);
      end
      frame_q.push_back(stop_val);
      for (int i = 1; i < STOP_BITS; i++) frame_q.push_back(1'b1);
   endtask

   task automatic tx_send_check(input logic [7:0] data, input logic [1:0] pm, input int div);
      int bt;
      baud_div = DIV_W'(div);
      parity_mode = pm;
      tx_data = data;
      tx_valid = 1'b1;
      vectors++;
      if (tx_ready !== 1'b1) begin
         errors++;
         $display("FAIL tx_ready_before_send: got %b expected 1", tx_ready);
      end
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      tx_data = 8'($urandom);
      baud_div = DIV_W'($urandom_range(0, 7));
      parity_mode = 2'($urandom_range(0, 3));
      build_frame(data, pm, 1'b1, 1'b0);
      bt = 16 * (div + 1);
      for (int k = 0; k < frame_q.size() * bt; k++) begin
         vectors++;
         if (tx !== frame_q[k / bt] || tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL tx_bit data=%h cycle %0d: got tx=%b ready=%b expected tx=%b ready=0",
                     data, k, tx, tx_ready, frame_q[k / bt]);
         end
         step();
      end
      vectors++;
      if (tx_ready !== 1'b1 || tx !== 1'b1) begin
         errors++;
         $display("FAIL tx_frame_end data=%h: got tx=%b ready=%b expected 1/1", data, tx, tx_ready);
      end
   endtask

   task automatic rx_drive(input logic [7:0] data, input logic [1:0] pm, input int div,
                           input bit stop_val, input bit flip_par);
      int bt;
      baud_div = DIV_W'(div);
      parity_mode = pm;
      build_frame(data, pm, stop_val, flip_par);
      bt = 16 * (div + 1);
      ovr_seen = 0;
      for (int b = 0; b < frame_q.size(); b++) begin
         rx_drv = frame_q[b];
         for (int c = 0; c < bt; c++) begin
            step();
            if (rx_overrun === 1'b1) ovr_seen++;
         end
         if (b == 0) begin
            baud_div = DIV_W'($urandom_range(0, 7));
            parity_mode = 2'($urandom_range(0, 3));
         end
      end
      rx_drv = 1'b1;
      for (int c = 0; c < 20; c++) begin
         step();
         if (rx_overrun === 1'b1) ovr_seen++;
      end
   endtask

   task automatic rx_expect(input string name, input logic [7:0] data, input bit pe, input bit fe);
      vectors++;
      if (rx_valid !== 1'b1 || rx_data !== data || rx_parity_err !== pe || rx_frame_err !== fe) begin
         errors++;
         $display("FAIL %s: got valid=%b data=%h pe=%b fe=%b expected 1 %h %b %b",
                  name, rx_valid, rx_data, rx_parity_err, rx_frame_err, data, pe, fe);
      end
   endtask

   task automatic rx_consume();
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
      vectors++;
      if (rx_valid !== 1'b0) begin
         errors++;
         $display("FAIL rx_consume: got rx_valid=%b expected 0", rx_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      vectors++;
      if (tx !== 1'b1 || tx_ready !== 1'b1 || rx_valid !== 1'b0 || rx_data !== 8'h00 ||
          rx_parity_err !== 1'b0 || rx_frame_err !== 1'b0 || rx_overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got tx=%b rdy=%b v=%b d=%h pe=%b fe=%b ov=%b expected 1 1 0 00 0 0 0",
                  tx, tx_ready, rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_overrun);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_tx_8e1();
      tx_send_check(8'hA5, 2'b01, 0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         tx_send_check(8'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 2));
      end
   endtask

   task automatic test_rx_random();
      logic [7:0] d;
      logic [1:0] pm;
      bit flip;
      for (int i = 0; i < 5; i++) begin
         d = 8'($urandom);
         pm = 2'($urandom_range(0, 3));
         flip = (pm == 2'b01 || pm == 2'b10) ? bit'($urandom_range(0, 1)) : 1'b0;
         rx_drive(d, pm, $urandom_range(0, 2), 1'b1, flip);
         rx_expect("rx_random", d, flip, 1'b0);
         rx_consume();
      end
   endtask

   task automatic test_frame_err();
      rx_drive(8'h55, 2'b00, 0, 1'b0, 1'b0);
      rx_expect("frame_err", 8'h55, 1'b0, 1'b1);
      rx_consume();
   endtask

   task automatic test_false_start();
      int seen;
      baud_div = '0;
      parity_mode = 2'b00;
      rx_drv = 1'b0;
      repeat (4) step();
      rx_drv = 1'b1;
      seen = 0;
      for (int c = 0; c < 60; c++) begin
         step();
         if (rx_valid !== 1'b0) seen++;
      end
      vectors++;
      if (seen != 0) begin
         errors++;
         $display("FAIL false_start: got rx_valid high %0d cycles expected 0", seen);
      end
      rx_drive(8'h81, 2'b00, 0, 1'b1, 1'b0);
      rx_expect("after_false_start", 8'h81, 1'b0, 1'b0);
      rx_consume();
   endtask

   task automatic test_overrun();
      rx_drive(8'h11, 2'b00, 0, 1'b1, 1'b0);
      rx_expect("overrun_first", 8'h11, 1'b0, 1'b0);
      rx_drive(8'h22, 2'b00, 0, 1'b1, 1'b0);
      vectors++;
      if (ovr_seen != 1) begin
         errors++;
         $display("FAIL overrun_pulse: got %0d pulses expected 1", ovr_seen);
      end
      rx_expect("overrun_hold", 8'h11, 1'b0, 1'b0);
      rx_consume();
   endtask

   task automatic test_loopback();
      int cyc;
      lb_wire = 1'b1;
      baud_div = 16'd3;
      parity_mode = 2'b10;
      tx_data = 8'h3C;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      cyc = 0;
      while (rx_valid !== 1'b1 && cyc < 900) begin
         step();
         cyc++;
      end
      vectors++;
      if (cyc < 640 || cyc > 720) begin
         errors++;
         $display("FAIL loopback_latency: got %0d cycles expected 640..720", cyc);
      end
      rx_expect("loopback_data", 8'h3C, 1'b0, 1'b0);
      cyc = 0;
      while (tx_ready !== 1'b1 && cyc < 200) begin
         step();
         cyc++;
      end
      vectors++;
      if (tx_ready !== 1'b1) begin
         errors++;
         $display("FAIL loopback_tx_done: got tx_ready=%b expected 1", tx_ready);
      end
      lb_wire = 1'b0;
      step();
      rx_consume();
   endtask

   task automatic test_reset_mid_tx();
      baud_div = '0;
      parity_mode = 2'b00;
      tx_data = 8'hFF;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      repeat (70) step();
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (tx !== 1'b1 || tx_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_tx: got tx=%b ready=%b expected 1/1", tx, tx_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      tx_send_check(8'h0F, 2'b00, 0);
   endtask

   initial begin
      test_reset();
      test_tx_8e1();
      test_back_to_back();
      test_rx_random();
      test_frame_err();
      test_false_start();
      test_overrun();
      test_loopback();
      test_reset_mid_tx();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
